read_sector_scheduler: RTL and testbench

- Rotational-position sequencer for the emulated ESDI read path.
- Generates the `sector_number` / `cycle_count` timebase that the read datapath compares against its queued sector id.
- Issues a prefetch request for the next sector a programmable lead time before that sector's start.
- Flags any request that was not accepted before its sector began (sector would be read from stale or no data).

---
 rtl/read_sector_scheduler_pkg.sv | 20 ++
 rtl/read_sector_scheduler_timebase.sv | 96 +++++++++
 rtl/read_sector_scheduler.sv | 178 +++++++++++++++++
 tb/tb_read_sector_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/read_sector_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : read_sector_scheduler_pkg
//  Purpose  : Shared state encoding and configuration clamp minima for the
//             read sector scheduler and the read datapath bench.
//  Revision : 1.0 - initial release
// ============================================================================
package read_sector_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int unsigned MIN_CYCLES_PER_SECTOR = 2;
  localparam int unsigned MIN_SECTORS_PER_TRACK = 1;

endpackage
`default_nettype wire

// File: rtl/read_sector_scheduler_timebase.sv
`default_nettype none
// ============================================================================
//  Module   : read_sector_scheduler_timebase
//  Purpose  : Rotational timebase. Counts clocks within a sector slot and
//             sectors within a track, and emits the sector/index pulses.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             start           - load zero timebase and pulse (first sector)
//             run             - advance one clock; when neither start nor run,
//                               the timebase is held at zero
//             spc, spt        - clamped cycles/sector and sectors/track
//             cycle_count     - clocks elapsed in current sector
//             sector_number   - current sector under head
//             next_sector     - (sector_number + 1) mod spt, combinational
//             sector_pulse    - high while cycle_count == 0 in a running slot
//             index_pulse     - high while cycle_count == 0 and sector 0
//             at_wrap         - cycle_count is at the last clock of the slot
//  Revision : 1.0 - initial release
// ============================================================================
module read_sector_scheduler_timebase
  import read_sector_scheduler_pkg::*;
#(
  parameter int CYCLE_W  = 32,
  parameter int SECTOR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                run,
  input  logic [CYCLE_W-1:0]  spc,
  input  logic [SECTOR_W-1:0] spt,
  output logic [CYCLE_W-1:0]  cycle_count,
  output logic [SECTOR_W-1:0] sector_number,
  output logic [SECTOR_W-1:0] next_sector,
  output logic                sector_pulse,
  output logic                index_pulse,
  output logic                at_wrap
);

  logic [CYCLE_W-1:0]  cycle_count_q,   cycle_count_d;
  logic [SECTOR_W-1:0] sector_number_q, sector_number_d;
  logic                sector_pulse_q,  sector_pulse_d;
  logic                index_pulse_q,   index_pulse_d;
  logic [SECTOR_W:0]   next_wide;

  // One extra bit so that spt = 2^SECTOR_W-1 does not alias on the increment.
  assign next_wide   = {1'b0, sector_number_q} + {{SECTOR_W{1'b0}}, 1'b1};
  assign next_sector = (next_wide >= {1'b0, spt}) ? '0 : next_wide[SECTOR_W-1:0];
  assign at_wrap     = (cycle_count_q == (spc - CYCLE_W'(1)));

  always_comb begin
    cycle_count_d   = cycle_count_q;
    sector_number_d = sector_number_q;
    sector_pulse_d  = 1'b0;
    index_pulse_d   = 1'b0;
    if (start) begin
      cycle_count_d   = '0;
      sector_number_d = '0;
      sector_pulse_d  = 1'b1;
      index_pulse_d   = 1'b1;
    end else if (run) begin
      if (at_wrap) begin
        cycle_count_d   = '0;
        sector_number_d = next_sector;
        // Pulses come from the wrapped values so they line up with count 0.
        sector_pulse_d  = 1'b1;
        index_pulse_d   = (next_sector == '0);
      end else begin
        cycle_count_d   = cycle_count_q + CYCLE_W'(1);
      end
    end else begin
      cycle_count_d   = '0;
      sector_number_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count_q   <= '0;
      sector_number_q <= '0;
      sector_pulse_q  <= 1'b0;
      index_pulse_q   <= 1'b0;
    end else begin
      cycle_count_q   <= cycle_count_d;
      sector_number_q <= sector_number_d;
      sector_pulse_q  <= sector_pulse_d;
      index_pulse_q   <= index_pulse_d;
    end
  end

  assign cycle_count   = cycle_count_q;
  assign sector_number = sector_number_q;
  assign sector_pulse  = sector_pulse_q;
  assign index_pulse   = index_pulse_q;

endmodule
`default_nettype wire

// File: rtl/read_sector_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : read_sector_scheduler
//  Purpose  : Rotational-position sequencer for the emulated ESDI read path.
//             Runs the sector timebase, issues a prefetch request for the
//             next sector a programmable lead before it starts, and flags
//             requests not accepted before their sector began.
//  Ports    : aclk, areset            - clock, synchronous active-high reset
//             enable                  - disk rotating
//             cfg_cycles_per_sector   - clocks per sector slot
//             cfg_sectors_per_track   - sectors per revolution
//             cfg_lead_cycles         - request lead before sector start
//             req_valid/ready/sector  - prefetch request handshake
//             sector_number, cycle_count, sector_pulse, index_pulse - timebase
//             late_pulse, late_sticky, late_clear - missed-request reporting
//  Revision : 1.0 - initial release
// ============================================================================
module read_sector_scheduler
  import read_sector_scheduler_pkg::*;
#(
  parameter int CYCLE_W  = 32,
  parameter int SECTOR_W = 8
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                enable,
  input  logic [CYCLE_W-1:0]  cfg_cycles_per_sector,
  input  logic [SECTOR_W-1:0] cfg_sectors_per_track,
  input  logic [CYCLE_W-1:0]  cfg_lead_cycles,
  output logic                req_valid,
  input  logic                req_ready,
  output logic [SECTOR_W-1:0] req_sector,
  output logic [SECTOR_W-1:0] sector_number,
  output logic [CYCLE_W-1:0]  cycle_count,
  output logic                sector_pulse,
  output logic                index_pulse,
  output logic                late_pulse,
  output logic                late_sticky,
  input  logic                late_clear
);

  state_e              state_q, state_d;
  logic [CYCLE_W-1:0]  spc_q, spc_d;
  logic [SECTOR_W-1:0] spt_q, spt_d;
  logic [CYCLE_W-1:0]  req_cycle_q, req_cycle_d;
  logic                req_valid_q, req_valid_d;
  logic [SECTOR_W-1:0] req_sector_q, req_sector_d;
  logic                late_pulse_q, late_pulse_d;
  logic                late_sticky_q, late_sticky_d;

  logic [CYCLE_W-1:0]  spc_clamped, spc_m1, lead_clamped;
  logic [SECTOR_W-1:0] spt_clamped;
  logic                tb_start, tb_run, tb_at_wrap;
  logic [SECTOR_W-1:0] tb_next_sector;

  // Clamped configuration, only consumed on the IDLE->ARM edge.
  always_comb begin
    spc_clamped  = (cfg_cycles_per_sector < CYCLE_W'(MIN_CYCLES_PER_SECTOR))
                 ? CYCLE_W'(MIN_CYCLES_PER_SECTOR) : cfg_cycles_per_sector;
    spt_clamped  = (cfg_sectors_per_track < SECTOR_W'(MIN_SECTORS_PER_TRACK))
                 ? SECTOR_W'(MIN_SECTORS_PER_TRACK) : cfg_sectors_per_track;
    spc_m1       = spc_clamped - CYCLE_W'(1);
    lead_clamped = (cfg_lead_cycles > spc_m1) ? spc_m1 : cfg_lead_cycles;
  end

  always_comb begin
    state_d       = state_q;
    spc_d         = spc_q;
    spt_d         = spt_q;
    req_cycle_d   = req_cycle_q;
    req_valid_d   = req_valid_q;
    req_sector_d  = req_sector_q;
    late_pulse_d  = 1'b0;
    late_sticky_d = late_clear ? 1'b0 : late_sticky_q;
    tb_start      = 1'b0;
    tb_run        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_valid_d  = 1'b0;
        req_sector_d = '0;
        if (enable) begin
          state_d      = ST_ARM;
          spc_d        = spc_clamped;
          spt_d        = spt_clamped;
          req_cycle_d  = spc_m1 - lead_clamped;
          req_valid_d  = 1'b1;
        end
      end

      ST_ARM: begin
        if (!enable) begin
          state_d      = ST_IDLE;
          req_valid_d  = 1'b0;
          req_sector_d = '0;
        end else if (req_valid_q && req_ready) begin
          state_d     = ST_RUN;
          req_valid_d = 1'b0;
          tb_start    = 1'b1;
        end
      end

      ST_RUN: begin
        if (!enable) begin
          // Withdrawn without a late event; the sticky flag survives.
          state_d      = ST_IDLE;
          req_valid_d  = 1'b0;
          req_sector_d = '0;
        end else begin
          tb_run = 1'b1;
          if (req_valid_q && req_ready) begin
            // Acceptance wins even when it lands on the wrap edge.
            req_valid_d = 1'b0;
          end else if (req_valid_q && tb_at_wrap) begin
            req_valid_d   = 1'b0;
            late_pulse_d  = 1'b1;
            late_sticky_d = 1'b1;
          end else if (!req_valid_q && (cycle_count == req_cycle_q)) begin
            req_valid_d  = 1'b1;
            req_sector_d = tb_next_sector;
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        req_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= ST_IDLE;
      spc_q         <= '0;
      spt_q         <= '0;
      req_cycle_q   <= '0;
      req_valid_q   <= 1'b0;
      req_sector_q  <= '0;
      late_pulse_q  <= 1'b0;
      late_sticky_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      spc_q         <= spc_d;
      spt_q         <= spt_d;
      req_cycle_q   <= req_cycle_d;
      req_valid_q   <= req_valid_d;
      req_sector_q  <= req_sector_d;
      late_pulse_q  <= late_pulse_d;
      late_sticky_q <= late_sticky_d;
    end
  end

  read_sector_scheduler_timebase #(
    .CYCLE_W  (CYCLE_W),
    .SECTOR_W (SECTOR_W)
  ) u_sector_timebase (
    .clk           (aclk),
    .rst           (areset),
    .start         (tb_start),
    .run           (tb_run),
    .spc           (spc_q),
    .spt           (spt_q),
    .cycle_count   (cycle_count),
    .sector_number (sector_number),
    .next_sector   (tb_next_sector),
    .sector_pulse  (sector_pulse),
    .index_pulse   (index_pulse),
    .at_wrap       (tb_at_wrap)
  );

  assign req_valid   = req_valid_q;
  assign req_sector  = req_sector_q;
  assign late_pulse  = late_pulse_q;
  assign late_sticky = late_sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_read_sector_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_read_sector_scheduler
//  Purpose  : Self-checking bench for read_sector_scheduler. Expected request
//             handshakes and late events are queued by the stimulus; a monitor
//             pops and compares them as the DUT presents them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_read_sector_scheduler;

  localparam int CYCLE_W  = 32;
  localparam int SECTOR_W = 8;

  logic                aclk = 1'b0;
  logic                areset = 1'b1;
  logic                enable = 1'b0;
  logic [CYCLE_W-1:0]  cfg_cycles_per_sector = '0;
  logic [SECTOR_W-1:0] cfg_sectors_per_track = '0;
  logic [CYCLE_W-1:0]  cfg_lead_cycles = '0;
  logic                req_ready = 1'b0;
  logic                late_clear = 1'b0;
  logic                req_valid;
  logic [SECTOR_W-1:0] req_sector;
  logic [SECTOR_W-1:0] sector_number;
  logic [CYCLE_W-1:0]  cycle_count;
  logic                sector_pulse;
  logic                index_pulse;
  logic                late_pulse;
  logic                late_sticky;

  always #5 aclk = ~aclk;

  read_sector_scheduler #(
    .CYCLE_W  (CYCLE_W),
    .SECTOR_W (SECTOR_W)
  ) dut (
    .aclk                  (aclk),
    .areset                (areset),
    .enable                (enable),
    .cfg_cycles_per_sector (cfg_cycles_per_sector),
    .cfg_sectors_per_track (cfg_sectors_per_track),
    .cfg_lead_cycles       (cfg_lead_cycles),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .req_sector            (req_sector),
    .sector_number         (sector_number),
    .cycle_count           (cycle_count),
    .sector_pulse          (sector_pulse),
    .index_pulse           (index_pulse),
    .late_pulse            (late_pulse),
    .late_sticky           (late_sticky),
    .late_clear            (late_clear)
  );

  typedef struct {
    bit late;
    int sec;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  sp_cnt   = 0;
  int  ip_cnt   = 0;
  int  sp0      = 0;
  int  ip0      = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic on_event(input bit late, input int sec, input int cyc);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_%s: got sector %0d cycle %0d, required no event (t=%0t)",
               late ? "late" : "handshake", sec, cyc, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind_late", int'(late), int'(e.late));
      check("event_sector", sec, e.sec);
      check("event_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: samples mid-cycle, when inputs and outputs are both settled.
  initial begin
    forever begin
      @(negedge aclk);
      if (!areset) begin
        if (req_valid && req_ready)
          on_event(1'b0, int'(req_sector), int'(cycle_count));
        if (late_pulse) begin
          check("late_withdraws_req", int'(req_valid), 0);
          on_event(1'b1, int'(sector_number), int'(cycle_count));
        end
        if (sector_pulse) begin
          sp_cnt++;
          check("sector_pulse_at_cc0", int'(cycle_count), 0);
        end
        if (index_pulse) begin
          ip_cnt++;
          check("index_pulse_at_sec0", int'(sector_number), 0);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #2;
    end
  endtask

  task automatic set_cfg(input int spc, input int spt, input int lead);
    cfg_cycles_per_sector = CYCLE_W'(spc);
    cfg_sectors_per_track = SECTOR_W'(spt);
    cfg_lead_cycles       = CYCLE_W'(lead);
  endtask

  task automatic exp_hs(input int sec, input int cyc);
    ev_t e;
    e.late = 1'b0; e.sec = sec; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic exp_late(input int sec);
    ev_t e;
    e.late = 1'b1; e.sec = sec; e.cyc = 0;
    exp_q.push_back(e);
  endtask

  task automatic snap;
    sp0 = sp_cnt;
    ip0 = ip_cnt;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_valid"},     int'(req_valid), 0);
    check({tag, "_req_sector"},    int'(req_sector), 0);
    check({tag, "_cycle_count"},   int'(cycle_count), 0);
    check({tag, "_sector_number"}, int'(sector_number), 0);
    check({tag, "_sector_pulse"},  int'(sector_pulse), 0);
    check({tag, "_index_pulse"},   int'(index_pulse), 0);
    check({tag, "_late_pulse"},    int'(late_pulse), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick(3);
    check_idle_outputs("reset");
    check("reset_late_sticky", int'(late_sticky), 0);
    areset = 1'b0;
    tick(1);

    // Basic rotation: requests raised at cc=6, visible and accepted at cc=7
    set_cfg(10, 4, 3);
    req_ready = 1'b1;
    exp_hs(0, 0); exp_hs(1, 7); exp_hs(2, 7); exp_hs(3, 7); exp_hs(0, 7); exp_hs(1, 7);
    snap();
    enable = 1'b1;
    tick(50);
    enable = 1'b0;
    tick(2);
    check("basic_sector_pulses", sp_cnt - sp0, 5);
    check("basic_index_pulses", ip_cnt - ip0, 2);
    check("basic_late_sticky", int'(late_sticky), 0);
    check_idle_outputs("basic_disabled");
    check("basic_drained", exp_q.size(), 0);

    // Backpressure within deadline: lead=5, request visible at cc=5
    set_cfg(10, 4, 5);
    req_ready = 1'b1;
    exp_hs(0, 0); exp_hs(1, 7);
    enable = 1'b1;
    tick(2);
    req_ready = 1'b0;
    tick(5);
    check("bp_valid_c0", int'(req_valid), 1);
    check("bp_sector_c0", int'(req_sector), 1);
    check("bp_cycle_c0", int'(cycle_count), 5);
    tick(1);
    check("bp_valid_c1", int'(req_valid), 1);
    check("bp_sector_c1", int'(req_sector), 1);
    tick(1);
    check("bp_valid_c2", int'(req_valid), 1);
    check("bp_sector_c2", int'(req_sector), 1);
    req_ready = 1'b1;
    tick(1);
    check("bp_accepted", int'(req_valid), 0);
    check("bp_no_late", int'(late_pulse), 0);
    enable = 1'b0;
    tick(2);
    check("bp_late_sticky", int'(late_sticky), 0);
    check("bp_drained", exp_q.size(), 0);

    // Ready coincident with the wrap edge
    set_cfg(10, 4, 3);
    req_ready = 1'b1;
    exp_hs(0, 0); exp_hs(1, 9); exp_hs(2, 7);
    enable = 1'b1;
    tick(2);
    req_ready = 1'b0;
    tick(9);
    req_ready = 1'b1;
    tick(1);
    check("wrap_hs_no_late", int'(late_pulse), 0);
    check("wrap_hs_cycle", int'(cycle_count), 0);
    check("wrap_hs_sector", int'(sector_number), 1);
    check("wrap_hs_valid", int'(req_valid), 0);
    tick(8);
    enable = 1'b0;
    tick(2);
    check("wrap_late_sticky", int'(late_sticky), 0);
    check("wrap_drained", exp_q.size(), 0);

    // Missed deadline with late_clear interplay
    set_cfg(10, 4, 3);
    req_ready = 1'b1;
    exp_hs(0, 0); exp_late(1); exp_late(2); exp_late(3);
    enable = 1'b1;
    tick(2);
    req_ready = 1'b0;
    tick(11);
    check("miss_sticky_set", int'(late_sticky), 1);
    check("miss_pulse_one_clock", int'(late_pulse), 0);
    tick(8);
    late_clear = 1'b1;
    tick(1);
    check("miss_set_wins_pulse", int'(late_pulse), 1);
    check("miss_set_wins_sticky", int'(late_sticky), 1);
    late_clear = 1'b0;
    tick(3);
    late_clear = 1'b1;
    tick(1);
    check("miss_clear_alone", int'(late_sticky), 0);
    late_clear = 1'b0;
    tick(7);
    check("miss_sticky_reset", int'(late_sticky), 1);
    enable = 1'b0;
    tick(2);
    check("miss_sticky_retained", int'(late_sticky), 1);
    check_idle_outputs("miss_disabled");
    check("miss_drained", exp_q.size(), 0);

    // Reset asserted while in ARM
    req_ready = 1'b0;
    enable = 1'b1;
    tick(1);
    check("arm_req_valid", int'(req_valid), 1);
    areset = 1'b1;
    tick(1);
    check_idle_outputs("arm_reset");
    check("arm_reset_late_sticky", int'(late_sticky), 0);
    areset = 1'b0;
    enable = 1'b0;
    tick(1);

    // Clamps: spc->2, spt->1, lead->1 so the request is raised at cc=0
    set_cfg(0, 0, 100);
    req_ready = 1'b1;
    exp_hs(0, 0); exp_hs(0, 1); exp_hs(0, 1); exp_hs(0, 1); exp_hs(0, 1);
    snap();
    enable = 1'b1;
    tick(10);
    enable = 1'b0;
    tick(2);
    check("clamp_sector_pulses", sp_cnt - sp0, 5);
    check("clamp_index_pulses", ip_cnt - ip0, 5);
    check("clamp_late_sticky", int'(late_sticky), 0);
    check("clamp_drained", exp_q.size(), 0);

    // Config change in RUN is ignored until re-enable
    set_cfg(10, 4, 3);
    req_ready = 1'b1;
    exp_hs(0, 0); exp_hs(1, 7); exp_hs(2, 7);
    snap();
    enable = 1'b1;
    tick(2);
    set_cfg(4, 2, 0);
    tick(23);
    enable = 1'b0;
    tick(1);
    check_idle_outputs("cfgchg_disabled");
    check("cfgchg_sector_pulses", sp_cnt - sp0, 3);
    check("cfgchg_index_pulses", ip_cnt - ip0, 1);
    check("cfgchg_drained", exp_q.size(), 0);

    // Re-enable picks up spc=4, spt=2, lead=0 (req_cycle=3)
    exp_hs(0, 0); exp_hs(1, 0); exp_hs(0, 0);
    snap();
    enable = 1'b1;
    tick(10);
    enable = 1'b0;
    tick(2);
    check("newcfg_sector_pulses", sp_cnt - sp0, 3);
    check("newcfg_index_pulses", ip_cnt - ip0, 2);
    check("newcfg_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
